// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the write-back path: widths, the zero register and
// the destination/data pair carried by any register-file write request.
package rv32_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [XLEN-1:0]   data;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO holding LU results that lost the register-file port.
// Pointers carry one wrap bit so full and empty are distinguishable.
module rf_wb_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    i_push,
  input  wb_req_t i_req,
  input  logic    i_pop,
  output wb_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wptr, r_rptr;
  wb_req_t     r_mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read once the pointers say they exist.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_req;
  end

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];
endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline WB and the
// long-latency unit, tracks in-flight LU destinations and raises ID hazards.
module rf_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int LU_BUF_DEPTH = 2,
  parameter int STARVE_MAX   = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              regwrite_wb,
  input  logic [REG_AW-1:0] dst_wb,
  input  logic [XLEN-1:0]   regwd_wb,
  input  logic              lu_valid,
  input  logic [REG_AW-1:0] lu_dst,
  input  logic [XLEN-1:0]   lu_data,
  output logic              lu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_dst,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic [REG_AW-1:0] dst_id,
  output logic              stall_id,
  output logic              wb_hold,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_dst,
  output logic [XLEN-1:0]   rf_wd
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic              w_full, w_empty;
  wb_req_t           w_head, w_lu_req;
  logic              w_hold, w_sel_pipe, w_pop, w_lu_live, w_bypass, w_push;
  logic              w_lu_wr;
  logic [REG_AW-1:0] w_lu_wr_dst;
  logic [SW-1:0]     r_starve;
  logic [31:0]       r_busy, w_busy_nxt;

  assign w_lu_req = '{dst: lu_dst, data: lu_data};

  rf_wb_fifo #(.DEPTH(LU_BUF_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_req   (w_lu_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Source select: pipeline unless held, then FIFO head, then a 0-cycle LU bypass.
  assign w_hold     = rstn && !w_empty && (r_starve == SW'(STARVE_MAX));
  assign w_sel_pipe = regwrite_wb && !w_hold;
  assign w_pop      = !w_sel_pipe && !w_empty;
  assign w_lu_live  = lu_valid && !w_full && (lu_dst != ZERO_REG);
  assign w_bypass   = !w_sel_pipe && w_empty && w_lu_live;
  assign w_push     = w_lu_live && !w_bypass;

  assign w_lu_wr     = w_pop || w_bypass;
  assign w_lu_wr_dst = w_pop ? w_head.dst : lu_dst;

  always_comb begin
    rf_we  = 1'b0;
    rf_dst = '0;
    rf_wd  = '0;
    if (rstn) begin
      if (w_sel_pipe) begin
        rf_we  = 1'b1;
        rf_dst = dst_wb;
        rf_wd  = regwd_wb;
      end else if (w_pop) begin
        rf_we  = 1'b1;
        rf_dst = w_head.dst;
        rf_wd  = w_head.data;
      end else if (w_bypass) begin
        rf_we  = 1'b1;
        rf_dst = lu_dst;
        rf_wd  = lu_data;
      end
    end
  end

  assign lu_ready = rstn && !w_full;
  assign wb_hold  = w_hold;

  // Counts cycles the FIFO head is blocked by the pipeline; a pop restarts it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  r_starve <= '0;
    else if (w_empty || w_pop)  r_starve <= '0;
    else if (w_sel_pipe)        r_starve <= r_starve + 1'b1;
  end

  // Set wins over clear so a re-issue to the same register in the retire cycle stays busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_lu_wr) w_busy_nxt[w_lu_wr_dst] = 1'b0;
    if (iss_valid && (iss_dst != ZERO_REG)) w_busy_nxt[iss_dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign stall_id = rstn && (((rs_id  != ZERO_REG) && r_busy[rs_id]) ||
                             ((rt_id  != ZERO_REG) && r_busy[rt_id]) ||
                             ((dst_id != ZERO_REG) && r_busy[dst_id]));

  ap_no_pipe_wr_busy: assert property (@(posedge clk) disable iff (!rstn)
    !(w_sel_pipe && (dst_wb != ZERO_REG) && r_busy[dst_wb]));
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed + random bench for rf_wb_arbiter against a queue-based reference model
// and an independent in-order log of accepted LU results.
module tb_rf_wb_arbiter;
  import rv32_pkg::*;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        regwrite_wb, lu_valid, iss_valid;
  logic [4:0]  dst_wb, lu_dst, iss_dst, rs_id, rt_id, dst_id;
  logic [31:0] regwd_wb, lu_data;
  logic        lu_ready, stall_id, wb_hold, rf_we;
  logic [4:0]  rf_dst;
  logic [31:0] rf_wd;

  rf_wb_arbiter #(.LU_BUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rstn(rstn),
    .regwrite_wb(regwrite_wb), .dst_wb(dst_wb), .regwd_wb(regwd_wb),
    .lu_valid(lu_valid), .lu_dst(lu_dst), .lu_data(lu_data), .lu_ready(lu_ready),
    .iss_valid(iss_valid), .iss_dst(iss_dst),
    .rs_id(rs_id), .rt_id(rt_id), .dst_id(dst_id), .stall_id(stall_id),
    .wb_hold(wb_hold), .rf_we(rf_we), .rf_dst(rf_dst), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  wb_req_t m_q[$];
  int      m_starve;
  bit      m_busy[32];
  bit      m_hold, m_pipe, m_pop, m_ready, m_live, m_byp;
  // Accepted LU results in acceptance order, matched against observed LU writes
  wb_req_t lu_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    regwrite_wb = 0; dst_wb = 0; regwd_wb = 0;
    lu_valid = 0; lu_dst = 0; lu_data = 0;
    iss_valid = 0; iss_dst = 0;
    rs_id = 0; rt_id = 0; dst_id = 0;
  endtask

  // Called shortly after the falling edge, with inputs already driven.
  task automatic eval();
    logic        e_we, e_stall;
    logic [4:0]  e_dst;
    logic [31:0] e_wd;
    wb_req_t     r;
    #2;
    e_we = 0; e_dst = 0; e_wd = 0; e_stall = 0;
    m_hold = 0; m_pipe = 0; m_pop = 0; m_ready = 0; m_live = 0; m_byp = 0;
    if (rstn) begin
      m_hold  = (m_q.size() > 0) && (m_starve == SMAX);
      m_pipe  = regwrite_wb && !m_hold;
      m_pop   = !m_pipe && (m_q.size() > 0);
      m_ready = m_q.size() < DEPTH;
      m_live  = lu_valid && m_ready && (lu_dst != 0);
      m_byp   = !m_pipe && (m_q.size() == 0) && m_live;
      if (m_pipe)     begin e_we = 1; e_dst = dst_wb;     e_wd = regwd_wb;    end
      else if (m_pop) begin e_we = 1; e_dst = m_q[0].dst; e_wd = m_q[0].data; end
      else if (m_byp) begin e_we = 1; e_dst = lu_dst;     e_wd = lu_data;     end
      e_stall = (rs_id != 0 && m_busy[rs_id]) || (rt_id != 0 && m_busy[rt_id]) ||
                (dst_id != 0 && m_busy[dst_id]);
    end
    chk("rf_we", rf_we, e_we);
    chk("rf_dst", rf_dst, e_dst);
    chk("rf_wd", rf_wd, e_wd);
    chk("lu_ready", lu_ready, m_ready);
    chk("wb_hold", wb_hold, m_hold);
    chk("stall_id", stall_id, e_stall);
    // Observation-driven ordering check: every non-pipeline write must be the oldest accepted LU result.
    if (!rstn) lu_log.delete();
    else begin
      if (lu_valid && lu_ready && lu_dst != 0) lu_log.push_back('{dst: lu_dst, data: lu_data});
      if (rf_we && !(regwrite_wb && !wb_hold)) begin
        if (lu_log.size() == 0) chk("lu_dup_write", 1, 0);
        else begin
          r = lu_log.pop_front();
          chk("lu_order_dst", rf_dst, r.dst);
          chk("lu_order_data", rf_wd, r.data);
        end
      end
    end
  endtask

  task automatic adv();
    bit empty_pre;
    int d;
    @(posedge clk);
    if (!rstn) begin
      m_q.delete();
      m_starve = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
    end else begin
      empty_pre = (m_q.size() == 0);
      d = -1;
      if (m_pop) d = m_q.pop_front().dst;
      else if (m_byp) d = lu_dst;
      if (d > 0) m_busy[d] = 0;
      if (m_live && !m_byp) m_q.push_back('{dst: lu_dst, data: lu_data});
      if (m_pop || empty_pre) m_starve = 0;
      else if (m_pipe) m_starve++;
      if (iss_valid && iss_dst != 0) m_busy[iss_dst] = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    int d;
    bit pend;
    m_starve = 0;
    idle();
    rstn = 0;
    @(negedge clk);
    eval(); adv();
    eval(); adv();
    rstn = 1;

    // 1: idle port, LU bypass in the same cycle
    idle(); lu_valid = 1; lu_dst = 7; lu_data = 32'h55;
    eval();
    chk("t1_we", rf_we, 1); chk("t1_dst", rf_dst, 7); chk("t1_wd", rf_wd, 32'h55);
    adv();

    // 2: pipeline hogs the port, two LU results queue, starvation forces holds
    idle(); regwrite_wb = 1; dst_wb = 3; regwd_wb = 32'h3333;
    lu_valid = 1; lu_dst = 10; lu_data = 32'hA0A0;
    eval(); adv();
    lu_dst = 11; lu_data = 32'hB1B1;
    eval(); adv();
    lu_valid = 0;
    eval(); chk("t2_full_ready", lu_ready, 0); adv();
    repeat (2) begin eval(); adv(); end
    eval(); chk("t2_hold1", wb_hold, 1); chk("t2_hold1_dst", rf_dst, 10); chk("t2_hold1_wd", rf_wd, 32'hA0A0); adv();
    repeat (4) begin eval(); adv(); end
    eval(); chk("t2_hold2", wb_hold, 1); chk("t2_hold2_dst", rf_dst, 11); adv();
    eval(); chk("t2_after_hold", wb_hold, 0); chk("t2_after_dst", rf_dst, 3); adv();

    // 3: issued LU op makes x9 busy until the cycle after its write
    idle(); iss_valid = 1; iss_dst = 9;
    eval(); adv();
    iss_valid = 0; rs_id = 9;
    eval(); chk("t3_stall", stall_id, 1); adv();
    eval(); adv();
    lu_valid = 1; lu_dst = 9; lu_data = 32'h9999;
    eval(); chk("t3_stall_wr", stall_id, 1); chk("t3_wr_dst", rf_dst, 9); adv();
    lu_valid = 0;
    eval(); chk("t3_stall_clr", stall_id, 0); adv();

    // 4: register 0 is never tracked nor written from the LU
    idle(); iss_valid = 1; iss_dst = 0; lu_valid = 1; lu_dst = 0; lu_data = 32'hDEAD;
    eval(); chk("t4_we", rf_we, 0); chk("t4_ready", lu_ready, 1); adv();
    idle();
    eval(); chk("t4_ready2", lu_ready, 1); adv();

    // 5: reset with a full FIFO and x4 busy flushes everything
    idle(); iss_valid = 1; iss_dst = 4; regwrite_wb = 1; dst_wb = 3; regwd_wb = 32'h1;
    lu_valid = 1; lu_dst = 12; lu_data = 32'hC;
    eval(); adv();
    iss_valid = 0; lu_dst = 13; lu_data = 32'hD;
    eval(); adv();
    lu_valid = 0; rs_id = 4;
    eval(); chk("t5_full", lu_ready, 0); chk("t5_busy", stall_id, 1); adv();
    rstn = 0; lu_valid = 1; lu_dst = 5; lu_data = 32'h77;
    eval();
    chk("t5_rst_we", rf_we, 0); chk("t5_rst_dst", rf_dst, 0); chk("t5_rst_wd", rf_wd, 0);
    chk("t5_rst_ready", lu_ready, 0); chk("t5_rst_stall", stall_id, 0); chk("t5_rst_hold", wb_hold, 0);
    adv();
    rstn = 1; idle(); rs_id = 4;
    eval(); chk("t5_post_stall", stall_id, 0); chk("t5_post_ready", lu_ready, 1); chk("t5_post_we", rf_we, 0); adv();

    // 6: random traffic; LU valid is held until accepted
    idle();
    pend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        lu_valid = ($urandom_range(2, 0) == 0);
        lu_dst   = 5'($urandom_range(31, 0));
        lu_data  = $urandom;
      end
      regwrite_wb = ($urandom_range(9, 0) < 6);
      do d = $urandom_range(31, 0); while (m_busy[d]);
      dst_wb   = 5'(d);
      regwd_wb = $urandom;
      iss_valid = ($urandom_range(3, 0) == 0);
      iss_dst   = 5'($urandom_range(31, 0));
      rs_id  = 5'($urandom_range(31, 0));
      rt_id  = 5'($urandom_range(31, 0));
      dst_id = 5'($urandom_range(31, 0));
      eval();
      pend = lu_valid && !lu_ready;
      adv();
    end

    // Drain: no new traffic, every accepted LU result must appear exactly once
    idle();
    repeat (2 * DEPTH + 2) begin eval(); adv(); end
    chk("drain_lost_writes", lu_log.size(), 0);
    chk("drain_ready", lu_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
